// File: rtl/seq_mult_hs.sv
// Sequential shift-add multiplier (signed/unsigned), one multiplier bit per cycle.
// Latency WIDTH cycles, or MSB(|b|)+1 with EARLY_EXIT; result held under out_ready backpressure.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready.
module seq_mult_hs #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_signed,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_product,
    output logic                 busy
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [PW-1:0]     r_ma;
    logic [WIDTH:0]    r_mb;
    logic [PW-1:0]     r_acc;
    logic              r_neg;
    logic [CW-1:0]     r_cnt;
    logic              r_out_valid;
    logic [PW-1:0]     r_out_product;

    logic [WIDTH:0]    w_a_ext;
    logic [WIDTH:0]    w_b_ext;
    logic [WIDTH:0]    w_a_mag;
    logic [WIDTH:0]    w_b_mag;
    logic [PW-1:0]     w_acc_sum;
    logic [PW-1:0]     w_result;
    logic              w_last;
    logic              w_accept;

    // One extra bit so that |-2^(W-1)| and unsigned operands are both plain magnitudes.
    assign w_a_ext   = {in_signed & in_a[WIDTH-1], in_a};
    assign w_b_ext   = {in_signed & in_b[WIDTH-1], in_b};
    assign w_a_mag   = w_a_ext[WIDTH] ? (~w_a_ext + 1'b1) : w_a_ext;
    assign w_b_mag   = w_b_ext[WIDTH] ? (~w_b_ext + 1'b1) : w_b_ext;

    assign w_acc_sum = r_acc + (r_mb[0] ? r_ma : '0);
    assign w_result  = r_neg ? (~w_acc_sum + 1'b1) : w_acc_sum;
    assign w_last    = (r_cnt == CW'(WIDTH - 1)) ||
                       (EARLY_EXIT && (r_mb[WIDTH:1] == '0));
    assign w_accept  = in_valid && (r_state == S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        busy        = 1'b1;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ma          <= '0;
            r_mb          <= '0;
            r_acc         <= '0;
            r_neg         <= 1'b0;
            r_cnt         <= '0;
            r_out_valid   <= 1'b0;
            r_out_product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_ma  <= PW'(w_a_mag);
                        r_mb  <= w_b_mag;
                        r_neg <= in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
                        r_acc <= '0;
                        r_cnt <= '0;
                    end
                end
                S_CALC: begin
                    r_acc <= w_acc_sum;
                    r_ma  <= r_ma << 1;
                    r_mb  <= r_mb >> 1;
                    r_cnt <= r_cnt + CW'(1);
                    // Sign is applied once, on the completing edge, to the final sum.
                    if (w_last) begin
                        r_out_product <= w_result;
                        r_out_valid   <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid   = r_out_valid;
    assign out_product = r_out_product;

endmodule

// File: tb/tb_seq_mult_hs.sv
// Scoreboard bench for seq_mult_hs: four lanes (W8/EE0, W8/EE1, W4/EE1, W16/EE0)
// driven with directed and random operations, checked against an arithmetic model.
module tb_seq_mult_hs;

    localparam int NL = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst_n;
    logic [NL-1:0]          iv, ir, isg, ov, ordy, bsy;
    logic [NL-1:0][15:0]    ia, ib;
    logic [NL-1:0][31:0]    prod;
    logic [15:0]            p0, p1;
    logic [7:0]             p2;
    logic [31:0]            p3;

    assign prod[0] = {16'd0, p0};
    assign prod[1] = {16'd0, p1};
    assign prod[2] = {24'd0, p2};
    assign prod[3] = p3;

    seq_mult_hs #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_l0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_signed(isg[0]),
        .in_a(ia[0][7:0]), .in_b(ib[0][7:0]), .out_valid(ov[0]), .out_ready(ordy[0]),
        .out_product(p0), .busy(bsy[0]));
    seq_mult_hs #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_signed(isg[1]),
        .in_a(ia[1][7:0]), .in_b(ib[1][7:0]), .out_valid(ov[1]), .out_ready(ordy[1]),
        .out_product(p1), .busy(bsy[1]));
    seq_mult_hs #(.WIDTH(4), .EARLY_EXIT(1'b1)) u_l2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_signed(isg[2]),
        .in_a(ia[2][3:0]), .in_b(ib[2][3:0]), .out_valid(ov[2]), .out_ready(ordy[2]),
        .out_product(p2), .busy(bsy[2]));
    seq_mult_hs #(.WIDTH(16), .EARLY_EXIT(1'b0)) u_l3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]), .in_signed(isg[3]),
        .in_a(ia[3]), .in_b(ib[3]), .out_valid(ov[3]), .out_ready(ordy[3]),
        .out_product(p3), .busy(bsy[3]));

    typedef struct {
        longint exp;
        int     lat;
        int     acc;
    } sb_t;

    sb_t           sbq [NL][$];
    int            n_chk  = 0;
    int            n_fail = 0;
    int            cyc    = 0;
    int            or_mode [NL];   // 0 random, 1 held high, 2 held low
    logic [NL-1:0] pv = '0;

    function automatic int lane_w(int k);
        case (k)
            0, 1:    return 8;
            2:       return 4;
            default: return 16;
        endcase
    endfunction

    function automatic bit lane_ee(int k);
        return (k == 1) || (k == 2);
    endfunction

    // Reference: integer multiply of the interpreted operands, latency from |b|.
    function automatic void model(int k, bit s, longint a, longint b,
                                  output longint p, output int lat);
        int     w  = lane_w(k);
        longint sa = a;
        longint sb = b;
        longint mag;
        if (s && (((a >> (w - 1)) & 1) != 0)) sa = a - (longint'(1) << w);
        if (s && (((b >> (w - 1)) & 1) != 0)) sb = b - (longint'(1) << w);
        p   = (sa * sb) & ((longint'(1) << (2 * w)) - 1);
        mag = (sb < 0) ? -sb : sb;
        if (!lane_ee(k)) begin
            lat = w;
        end else begin
            lat = 1;
            for (int i = 0; i <= w; i++)
                if (((mag >> i) & 1) != 0) lat = i + 1;
        end
    endfunction

    task automatic check(string nm, int k, longint act, longint req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL lane%0d %s: got %0h required %0h", k, nm, act, req);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        for (int k = 0; k < NL; k++)
            ordy[k] = (or_mode[k] == 0) ? 1'($urandom_range(0, 1)) : (or_mode[k] == 1);
    end

    always @(negedge clk) begin
        for (int k = 0; k < NL; k++) begin
            if (rst_n && ov[k]) begin
                if (sbq[k].size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL lane%0d unexpected_result: got %0h required none", k, prod[k]);
                end else begin
                    if (!pv[k])
                        check("latency", k, longint'(cyc - sbq[k][0].acc), longint'(sbq[k][0].lat));
                    check("product", k, longint'(prod[k]) & ((longint'(1) << (2 * lane_w(k))) - 1),
                          sbq[k][0].exp);
                    check("in_ready_while_valid", k, longint'(ir[k]), 0);
                    if (ordy[k]) void'(sbq[k].pop_front());
                end
            end
            pv[k] = ov[k];
        end
    end

    task automatic do_op(int k, bit s, longint a, longint b);
        sb_t e;
        int  t = 0;
        @(negedge clk);
        isg[k] = s;
        ia[k]  = 16'(a);
        ib[k]  = 16'(b);
        iv[k]  = 1'b1;
        while (!ir[k] && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) begin
            n_chk++;
            n_fail++;
            $display("FAIL lane%0d accept_timeout: got in_ready=0 required 1", k);
            iv[k] = 1'b0;
            return;
        end
        @(negedge clk);
        iv[k] = 1'b0;
        ia[k] = 16'($urandom);
        ib[k] = 16'($urandom);
        model(k, s, a, b, e.exp, e.lat);
        e.acc = cyc;
        sbq[k].push_back(e);
    endtask

    task automatic wait_valid(int k);
        int t = 0;
        while (!ov[k] && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("valid_timeout", k, longint'(ov[k]), 1);
    endtask

    task automatic wait_idle(int k);
        int t = 0;
        while ((sbq[k].size() != 0 || !ir[k]) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("drain", k, longint'(sbq[k].size()), 0);
    endtask

    function automatic longint pick(int w);
        case ($urandom_range(0, 7))
            0:       return 0;
            1:       return (longint'(1) << w) - 1;
            2:       return longint'(1) << (w - 1);
            3:       return 1;
            default: return longint'($urandom_range(0, (1 << w) - 1));
        endcase
    endfunction

    task automatic run_rand(int k, int n);
        int w = lane_w(k);
        for (int i = 0; i < n; i++) begin
            do_op(k, 1'($urandom_range(0, 1)), pick(w), pick(w));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle(k);
    endtask

    task automatic check_reset_outputs();
        for (int k = 0; k < NL; k++) begin
            check("rst_out_valid", k, longint'(ov[k]), 0);
            check("rst_in_ready", k, longint'(ir[k]), 1);
            check("rst_busy", k, longint'(bsy[k]), 0);
            check("rst_product", k, longint'(prod[k]), 0);
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got no finish required finish");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        iv = '0; isg = '0; ia = '0; ib = '0; ordy = '1;
        for (int k = 0; k < NL; k++) or_mode[k] = 1;
        #12;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Directed products and latencies.
        do_op(0, 1'b0, 255, 255);       wait_idle(0);
        do_op(0, 1'b1, 8'h80, 8'h80);   wait_idle(0);
        do_op(0, 1'b1, 8'hFD, 5);       wait_idle(0);
        do_op(0, 1'b1, 7, 8'hFF);       wait_idle(0);
        do_op(0, 1'b1, 0, 8'h80);       wait_idle(0);
        do_op(1, 1'b0, 200, 1);         wait_idle(1);
        do_op(1, 1'b0, 3, 0);           wait_idle(1);
        do_op(1, 1'b0, 1, 128);         wait_idle(1);
        do_op(1, 1'b1, 5, 8'h80);       wait_idle(1);
        do_op(2, 1'b1, 4'h8, 4'h8);     wait_idle(2);
        do_op(3, 1'b0, 16'hFFFF, 16'hFFFF); wait_idle(3);

        // Backpressure with ignored in_valid pulses in CALC and DONE.
        or_mode[0] = 2;
        do_op(0, 1'b1, 8'hFD, 5);
        iv[0] = 1'b1; ia[0] = 16'd9; ib[0] = 16'd9;
        @(negedge clk);
        iv[0] = 1'b0;
        wait_valid(0);
        for (int i = 0; i < 5; i++) begin
            iv[0] = (i == 2);
            @(negedge clk);
        end
        iv[0] = 1'b0;
        or_mode[0] = 1;
        wait_idle(0);
        repeat (30) @(negedge clk);
        check("no_second_result", 0, longint'(ov[0]), 0);

        // Asynchronous reset in the third CALC cycle.
        do_op(0, 1'b0, 255, 255);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        sbq[0].delete();
        @(negedge clk);
        rst_n = 1'b1;
        do_op(0, 1'b0, 12, 12);
        wait_idle(0);

        for (int k = 0; k < NL; k++) or_mode[k] = 0;
        fork
            run_rand(0, 150);
            run_rand(1, 150);
            run_rand(2, 150);
            run_rand(3, 100);
        join
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
